// File: rtl/memstage.sv
// Memory-access pipeline stage: RV32I loads/stores over a req/gnt/rvalid bus,
// with alignment/funct3 fault detection and a bus watchdog.

package riscv_pkg;
    typedef logic [31:0] instruction_t;
endpackage

module memstage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    load_i,
    input  logic                    store_i,
    input  logic [2:0]              funct3_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    input  riscv_pkg::instruction_t instruction_i,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [31:0]             dmem_addr_o,
    output logic [3:0]              dmem_be_o,
    output logic [31:0]             dmem_wdata_o,
    input  logic                    dmem_gnt_i,
    input  logic                    dmem_rvalid_i,
    input  logic [31:0]             dmem_rdata_i,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    output riscv_pkg::instruction_t instruction_o,
    output logic                    misaligned_o,
    output logic                    bus_error_o
);

    localparam int unsigned CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    is_load_q, is_load_d;
    logic [31:0]             addr_q, addr_d;
    logic [2:0]              f3_q, f3_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wdata_q, wdata_d;
    riscv_pkg::instruction_t instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic [31:0]             result_q, result_d;
    riscv_pkg::instruction_t instr_o_q, instr_o_d;
    logic                    mis_q, mis_d;
    logic                    berr_q, berr_d;

    // Accept-side decode of the incoming op
    logic        in_mem, in_fault, in_illegal, in_misal;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    // Load data aligned and extended from the captured offset/width
    logic [31:0] rd_shift, rd_ext;
    logic        timeout;

    // Decode width, byte enables, lane replication and fault conditions
    always_comb begin
        in_mem   = load_i | store_i;
        in_be    = 4'b1111;
        in_wdata = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                in_be    = 4'b0001 << addr_i[1:0];
                in_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                in_be    = 4'b0011 << {addr_i[1], 1'b0};
                in_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = wdata_i;
            end
        endcase
        // load_i wins when both are set, so store legality only applies to pure stores
        if (load_i) begin
            in_illegal = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
        end else begin
            in_illegal = (funct3_i >= 3'b011);
        end
        in_misal = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        in_fault = in_illegal | in_misal;
    end

    // Shift the addressed byte/half down to bit 0 and extend per funct3
    always_comb begin
        rd_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_ext = {24'h000000, rd_shift[7:0]};
            3'b101:  rd_ext = {16'h0000, rd_shift[15:0]};
            default: rd_ext = dmem_rdata_i;
        endcase
    end

    // Next-state, capture and completion logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        is_load_d = is_load_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        instr_o_d = instr_o_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        timeout   = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TLIM));

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    is_load_d = load_i;
                    addr_d    = addr_i;
                    f3_d      = funct3_i;
                    be_d      = in_be;
                    wdata_d   = in_wdata;
                    instr_d   = instruction_i;
                    if (!in_mem || in_fault) begin
                        valid_d   = 1'b1;
                        result_d  = addr_i;
                        instr_o_d = instruction_i;
                        mis_d     = in_mem & in_fault;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CW'(1);
                // A store grant completes the op even on the last watchdog cycle;
                // a load grant that late would still need rvalid, so it aborts.
                if (dmem_gnt_i && !is_load_q) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    result_d  = addr_q;
                    instr_o_d = instr_q;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    berr_d    = 1'b1;
                    result_d  = addr_q;
                    instr_o_d = instr_q;
                end else if (dmem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (dmem_rvalid_i) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    result_d  = rd_ext;
                    instr_o_d = instr_q;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    berr_d    = 1'b1;
                    result_d  = addr_q;
                    instr_o_d = instr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured op and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            addr_q    <= '0;
            f3_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            instr_o_q <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            instr_o_q <= instr_o_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign dmem_req_o    = (state_q == S_REQ);
    assign dmem_we_o     = (state_q == S_REQ) && !is_load_q;
    assign dmem_addr_o   = {addr_q[31:2], 2'b00};
    assign dmem_be_o     = be_q;
    assign dmem_wdata_o  = wdata_q;
    assign valid_o       = valid_q;
    assign result_o      = result_q;
    assign instruction_o = instr_o_q;
    assign misaligned_o  = mis_q;
    assign bus_error_o   = berr_q;

endmodule
